uart_rx: RTL

- UART receive stage sitting directly downstream of the baud-rate tick generator.
- Consumes the 16x-oversampling enable `s_tick` and the serial line `rx`.
- Deserialises 1 start bit, DBIT data bits (LSB first) and a stop period.
- Presents a parallel byte with a one-cycle `rx_done_tick` and a framing-error flag to the FIFO/host interface.

---
 rtl/uart_pkg.sv | 21 ++
 rtl/sync_2ff.sv | 23 ++
 rtl/uart_rx.sv | 128 ++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and constants for the UART receive path
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_t;

    localparam int OVERSAMPLE = 16;
    localparam int MID_START  = 7;

    // Tick counter must reach SB_TICK-1 but never narrower than one bit period.
    function automatic int cnt_width(input int sb_tick);
        int w;
        w = $clog2(sb_tick);
        return (w < 4) ? 4 : w;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - generic two-flop synchroniser with configurable reset value
module sync_2ff #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 16x oversampled UART receiver with done pulse and framing-error flag
module uart_rx
    import uart_pkg::*;
#(
    parameter int DBIT    = 8,
    parameter int SB_TICK = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            rx,
    input  logic            s_tick,
    output logic [DBIT-1:0] dout,
    output logic            rx_done_tick,
    output logic            frame_err
);

    localparam int SW = cnt_width(SB_TICK);
    localparam int NW = $clog2(DBIT);

    localparam logic [SW-1:0] S_MID      = SW'(MID_START);
    localparam logic [SW-1:0] S_BIT_END  = SW'(OVERSAMPLE - 1);
    localparam logic [SW-1:0] S_STOP_END = SW'(SB_TICK - 1);
    localparam logic [NW-1:0] N_LAST     = NW'(DBIT - 1);

    logic            rx_s;
    rx_state_t       state_reg, state_next;
    logic [SW-1:0]   s_reg, s_next;
    logic [NW-1:0]   n_reg, n_next;
    logic [DBIT-1:0] b_reg, b_next;
    logic            done_next;

    sync_2ff #(
        .RESET_VAL(1'b1)
    ) u_rx_sync (
        .clk  (clk),
        .reset(reset),
        .d    (rx),
        .q    (rx_s)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
            s_reg     <= '0;
            n_reg     <= '0;
            b_reg     <= '0;
        end else begin
            state_reg <= state_next;
            s_reg     <= s_next;
            n_reg     <= n_next;
            b_reg     <= b_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        s_next     = s_reg;
        n_next     = n_reg;
        b_next     = b_reg;
        done_next  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (!rx_s) begin
                    state_next = START;
                    s_next     = '0;
                end
            end
            START: begin
                if (s_tick) begin
                    // Mid start bit: a line back high here is treated as a glitch.
                    if (s_reg == S_MID) begin
                        if (!rx_s) begin
                            state_next = DATA;
                            s_next     = '0;
                            n_next     = '0;
                        end else begin
                            state_next = IDLE;
                        end
                    end else begin
                        s_next = s_reg + 1'b1;
                    end
                end
            end
            DATA: begin
                if (s_tick) begin
                    if (s_reg == S_BIT_END) begin
                        s_next = '0;
                        b_next = {rx_s, b_reg[DBIT-1:1]};
                        if (n_reg == N_LAST) begin
                            state_next = STOP;
                        end else begin
                            n_next = n_reg + 1'b1;
                        end
                    end else begin
                        s_next = s_reg + 1'b1;
                    end
                end
            end
            STOP: begin
                if (s_tick) begin
                    if (s_reg == S_STOP_END) begin
                        state_next = IDLE;
                        done_next  = 1'b1;
                    end else begin
                        s_next = s_reg + 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Outputs are registered so dout/frame_err change together with the done pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dout         <= '0;
            frame_err    <= 1'b0;
            rx_done_tick <= 1'b0;
        end else begin
            rx_done_tick <= done_next;
            if (done_next) begin
                dout      <= b_reg;
                frame_err <= ~rx_s;
            end
        end
    end

endmodule
